alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at rising edge.
REQ-006 cmd_op  input  4  ALU opcode (0-11 narrow result, 12-15 wide result).
REQ-007 cmd_a / cmd_b / cmd_c  input  16 each  operands.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  result consumed when rsp_valid & rsp_ready at rising edge.
REQ-010 rsp_data  output  32  result; narrow ops zero-extended.
REQ-011 rsp_wide  output  1  1 when returned op was 12-15.
REQ-012 alu_a / alu_b / alu_c  output  16 each  operands driven to ALU.
REQ-013 alu_s  output  4  opcode driven to ALU.
REQ-014 alu_d  input  16  ALU narrow result (registered in ALU, 1-edge latency).
REQ-015 alu_e  input  32  ALU wide result (registered in ALU, 1-edge latency).
REQ-016 busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-017 Commands SHALL be written to a DEPTH-entry circular FIFO; read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-018 cmd_ready SHALL equal (count != DEPTH); a push with simultaneous pop while full SHALL NOT occur (cmd_ready low).
REQ-019 FSM states: IDLE, ISSUE, CAPTURE, RESP.
REQ-020 IDLE -> ISSUE when FIFO non-empty; transition pops head into hold register (op, a, b, c).
REQ-021 alu_s/alu_a/alu_b/alu_c SHALL be registered outputs loaded from head on the pop edge and held until the next pop.
REQ-022 ISSUE -> CAPTURE unconditionally (ALU samples operands on this edge).
REQ-023 CAPTURE -> RESP unconditionally; on this edge rsp_data SHALL load {16'h0, alu_d} for op 0-11, alu_e for op 12-15; rsp_wide = op[3]&op[2].
REQ-024 In RESP rsp_valid SHALL be 1; rsp_data/rsp_wide SHALL remain stable until handshake.
REQ-025 RESP on handshake: -> ISSUE with pop if FIFO non-empty, else -> IDLE; without handshake remain in RESP.
REQ-026 Latency: from accept edge with FSM IDLE and FIFO empty, rsp_valid SHALL rise after the 3rd following rising edge; back-to-back throughput one result per 3 cycles with rsp_ready held high.
REQ-027 Results SHALL be returned in command order; no command dropped or duplicated.
REQ-028 Push into FIFO SHALL be permitted while FSM is in any state, including same-edge push and pop when not full.

Reset
REQ-029 rst_n low SHALL asynchronously clear pointers, count, hold register, alu_* outputs, rsp_data, rsp_wide to 0 and FSM to IDLE; cmd_ready=1, rsp_valid=0, busy=0.
REQ-030 Reset mid-operation SHALL discard FIFO contents and any in-flight command; no response issued after release.
REQ-031 First command after rst_n deassertion SHALL be accepted on the first rising edge with cmd_valid high.

Configuration
REQ-032 Macro ALU_ISSUE_TAG_EN defined: ports cmd_tag (input 4) and rsp_tag (output 4) exist; tag stored per FIFO entry and returned with its result; rsp_tag resets to 0.
REQ-033 ALU_ISSUE_TAG_EN undefined: no tag ports or storage; all other behaviour identical.

Verification
REQ-034 op=0111, a=0x0003, b=0x0005 -> rsp_data=0x00000008, rsp_wide=0, rsp_valid 3 edges after accept.
REQ-035 op=1110, a=0x0100, b=0x0100 -> rsp_data=0x00010000, rsp_wide=1.
REQ-036 rsp_ready=0, push 6 commands (DEPTH=4) -> first 5 accepted, cmd_ready low from 5th accept; release rsp_ready -> 5 results in order, then cmd_ready high.
REQ-037 Stream 10 ops (alternating 0000 a=0xFF00 b=0x0FF0 -> 0x00000F00 and 1000 a=0x0000 b=0x0001 -> 0x0000FFFF) with rsp_ready=1 -> pointer wrap exercised, results in order, 3-cycle spacing.
REQ-038 rst_n pulsed low while FSM in CAPTURE with 2 entries queued -> rsp_valid=0, busy=0, cmd_ready=1 immediately; no response after release.
REQ-039 With ALU_ISSUE_TAG_EN: tags 0xA, 0x3 on two commands -> rsp_tag 0xA then 0x3 matching results.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command FIFO and issue/capture/response sequencer for a registered ALU
//
// Purpose:
//   Buffers ALU commands in a DEPTH-entry circular FIFO and runs each one
//   through a registered ALU (one-edge latency): IDLE -> ISSUE -> CAPTURE -> RESP.
//   Results are returned in command order over a valid/ready response port.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_a, cmd_b, cmd_c   opcode (12-15 = wide result) and operands
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_wide            result (narrow zero-extended), wide flag
//   alu_s, alu_a, alu_b, alu_c    registered opcode/operands to the ALU
//   alu_d, alu_e                  ALU narrow / wide results
//   busy                          FIFO non-empty or sequencer active
//   cmd_tag, rsp_tag              only with ALU_ISSUE_TAG_EN defined
//
// Configuration macro: ALU_ISSUE_TAG_EN (per-command 4-bit tag returned with result)
`timescale 1ns/1ps

module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [15:0] cmd_c,
`ifdef ALU_ISSUE_TAG_EN
  input  logic [3:0]  cmd_tag,
  output logic [3:0]  rsp_tag,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wide,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [15:0] alu_c,
  output logic [3:0]  alu_s,
  input  logic [15:0] alu_d,
  input  logic [31:0] alu_e,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_pop;
  logic            w_push;
  logic            w_empty;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [51:0]     r_mem [DEPTH];
  logic [51:0]     w_head;
  logic [3:0]      r_alu_s;
  logic [15:0]     r_alu_a;
  logic [15:0]     r_alu_b;
  logic [15:0]     r_alu_c;
  logic [31:0]     r_rsp_data;
  logic            r_rsp_wide;

  assign w_empty   = (r_count == '0);
  assign cmd_ready = (r_count != FULL);
  assign w_push    = cmd_valid & cmd_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = !w_empty || (r_state != S_IDLE);
  assign alu_s     = r_alu_s;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_c     = r_alu_c;
  assign rsp_data  = r_rsp_data;
  assign rsp_wide  = r_rsp_wide;

  // Sequencer: a pop happens only when leaving IDLE or RESP towards ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_ISSUE;
          w_pop       = 1'b1;
        end
      end
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_state_nxt = S_ISSUE;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Entry storage carries no reset; validity is tracked by pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_c};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The ALU-facing registers double as the hold register for the command
  // in flight; they stay put until the next pop, so alu_s still describes
  // the command when its result is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_s    <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_c    <= '0;
      r_rsp_data <= '0;
      r_rsp_wide <= 1'b0;
    end else begin
      if (w_pop) begin
        r_alu_s <= w_head[51:48];
        r_alu_a <= w_head[47:32];
        r_alu_b <= w_head[31:16];
        r_alu_c <= w_head[15:0];
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_wide <= r_alu_s[3] & r_alu_s[2];
        r_rsp_data <= (r_alu_s[3] & r_alu_s[2]) ? alu_e : {16'h0000, alu_d};
      end
    end
  end

`ifdef ALU_ISSUE_TAG_EN
  logic [3:0] r_tag_mem [DEPTH];
  logic [3:0] r_hold_tag;
  logic [3:0] r_rsp_tag;

  assign rsp_tag = r_rsp_tag;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_tag <= '0;
      r_rsp_tag  <= '0;
    end else begin
      if (w_pop) begin
        r_hold_tag <= r_tag_mem[r_rd_ptr];
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_tag <= r_hold_tag;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl
`timescale 1ns/1ps

module tb_alu_issue_ctrl;

  typedef struct packed {
    logic        wide;
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [15:0] cmd_c = '0;
  logic [3:0]  cmd_tag = '0;
`ifdef ALU_ISSUE_TAG_EN
  logic [3:0]  rsp_tag;
`endif
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_wide;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_s;
  logic [15:0] alu_d = '0;
  logic [31:0] alu_e = '0;
  logic        busy;

  int   n_checks = 0;
  int   n_fails = 0;
  int   n_rsp = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic have_last = 1'b0;
  logic spacing_on = 1'b0;
  logic stall_prev = 1'b0;
  logic [32:0] prev_rsp = '0;
  logic rand_done = 1'b0;
  int   dummy_wait;
  int   n0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_c     (cmd_c),
`ifdef ALU_ISSUE_TAG_EN
    .cmd_tag   (cmd_tag),
    .rsp_tag   (rsp_tag),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_wide  (rsp_wide),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_s     (alu_s),
    .alu_d     (alu_d),
    .alu_e     (alu_e),
    .busy      (busy)
  );

  // ALU behaviour; each bus carries junk for the opposite class of op so
  // that a wrong result-bus selection is visible.
  function automatic logic [15:0] fn_d(input logic [3:0] op, input logic [15:0] a, b, c);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return ~a;
      4'd4:    return a << b[3:0];
      4'd5:    return a >> b[3:0];
      4'd6:    return a + c;
      4'd7:    return a + b;
      4'd8:    return a - b;
      4'd9:    return a - c;
      4'd10:   return (a < b) ? 16'd1 : 16'd0;
      4'd11:   return a + b + c;
      default: return a ^ b ^ c ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [31:0] fn_e(input logic [3:0] op, input logic [15:0] a, b, c);
    case (op)
      4'd12:   return {a, b};
      4'd13:   return 32'(a) * 32'(c);
      4'd14:   return 32'(a) * 32'(b);
      4'd15:   return {c, a};
      default: return {b, a} ^ 32'hA5A5_0000;
    endcase
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, b, c, input logic [3:0] tag);
    exp_t e;
    e.tag  = tag;
    e.wide = (op >= 4'd12);
    e.data = e.wide ? fn_e(op, a, b, c) : {16'h0000, fn_d(op, a, b, c)};
    return e;
  endfunction

  always @(posedge clk) begin
    alu_d <= fn_d(alu_s, alu_a, alu_b, alu_c);
    alu_e <= fn_e(alu_s, alu_a, alu_b, alu_c);
    cyc   <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: scoreboard order, hold-while-stalled, optional spacing.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
      have_last  <= 1'b0;
    end else begin
      if (stall_prev)
        check("rsp_hold", 64'({rsp_valid, rsp_wide, rsp_data}), 64'({1'b1, prev_rsp}));
      stall_prev <= rsp_valid && !rsp_ready;
      prev_rsp   <= {rsp_wide, rsp_data};
      if (!spacing_on) have_last <= 1'b0;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(1), 64'(0));
        end else begin
          check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
          check("rsp_wide", 64'(rsp_wide), 64'(exp_q[0].wide));
`ifdef ALU_ISSUE_TAG_EN
          check("rsp_tag", 64'(rsp_tag), 64'(exp_q[0].tag));
`endif
          exp_q.delete(0);
        end
        if (spacing_on && have_last)
          check("rsp_spacing", 64'(cyc - last_cyc), 64'(3));
        if (spacing_on) have_last <= 1'b1;
        last_cyc <= cyc;
        n_rsp    <= n_rsp + 1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, b, c, input logic [3:0] tag, output int waited);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_c = c; cmd_tag = tag;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 60) begin
      waited++;
      @(negedge clk);
    end
    if (cmd_ready) exp_q.push_back(model(op, a, b, c, tag));
    else check("cmd_accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_wide", 64'(rsp_wide), 64'(0));
    check("rst_alu_regs", 64'({alu_s, alu_a, alu_b, alu_c}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // add 3+5 with latency profile; first command after reset accepted at once
    send(4'b0111, 16'h0003, 16'h0005, 16'h0000, 4'h1, dummy_wait);
    check("first_accept_wait", 64'(dummy_wait), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lat_rsp_valid", 64'(rsp_valid), 64'(k == 3));
      if (k == 3) begin
        check("lat_rsp_data", 64'(rsp_data), 64'h8);
        check("lat_rsp_wide", 64'(rsp_wide), 64'(0));
      end
    end
    @(posedge clk); #1;
    drain(20);

    // wide multiply
    send(4'b1110, 16'h0100, 16'h0100, 16'h0000, 4'h2, dummy_wait);
    dummy_wait = 0;
    @(negedge clk);
    while (!rsp_valid && dummy_wait < 20) begin
      dummy_wait++;
      @(negedge clk);
    end
    check("wide_rsp_valid", 64'(rsp_valid), 64'(1));
    check("wide_rsp_data", 64'(rsp_data), 64'h0001_0000);
    check("wide_rsp_wide", 64'(rsp_wide), 64'(1));
    @(posedge clk); #1;
    drain(20);

    // back-pressure fills hold register plus 4 FIFO entries
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 4'(i * 3); cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_c = 16'($urandom);
      cmd_tag = 4'(i);
      @(negedge clk);
      check("full_ready_before_push", 64'(cmd_ready), 64'(i < 5));
      if (cmd_ready) exp_q.push_back(model(cmd_op, cmd_a, cmd_b, cmd_c, cmd_tag));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("full_cmd_ready_low", 64'(cmd_ready), 64'(0));
    check("full_busy", 64'(busy), 64'(1));
    check("full_rsp_valid", 64'(rsp_valid), 64'(1));
    n0 = n_rsp;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain(80);
    check("full_rsp_count", 64'(n_rsp - n0), 64'(5));
    @(negedge clk);
    check("full_after_ready", 64'(cmd_ready), 64'(1));
    check("full_after_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;

    // streaming, 3-cycle spacing, pointer wrap
    spacing_on = 1'b1;
    n0 = n_rsp;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) send(4'b0000, 16'hFF00, 16'h0FF0, 16'($urandom), 4'(i), dummy_wait);
      else            send(4'b1000, 16'h0000, 16'h0001, 16'($urandom), 4'(i), dummy_wait);
    end
    drain(100);
    spacing_on = 1'b0;
    check("stream_rsp_count", 64'(n_rsp - n0), 64'(10));

    // random commands, gaps and back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom),
               4'($urandom_range(0, 15)), dummy_wait);
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    drain(200);

`ifdef ALU_ISSUE_TAG_EN
    send(4'd7, 16'h0011, 16'h0022, 16'h0000, 4'hA, dummy_wait);
    send(4'd12, 16'h1234, 16'h5678, 16'h0000, 4'h3, dummy_wait);
    drain(40);
`endif

    // reset while in CAPTURE with two entries queued
    send(4'd1, 16'h1111, 16'h2222, 16'h0000, 4'h4, dummy_wait);
    send(4'd2, 16'h3333, 16'h4444, 16'h0000, 4'h5, dummy_wait);
    send(4'd13, 16'h0005, 16'h0006, 16'h0007, 4'h6, dummy_wait);
    check("pre_reset_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    exp_q.delete();
    n0 = n_rsp;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_rsp_after_reset", 64'(n_rsp - n0), 64'(0));
    check("idle_after_reset", 64'(busy), 64'(0));
    send(4'd11, 16'h0001, 16'h0002, 16'h0003, 4'h7, dummy_wait);
    drain(20);
    check("post_reset_rsp_count", 64'(n_rsp - n0), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
